// File: rtl/b2r_converter_h.sv
`default_nettype none
// ============================================================================
// b2r_converter_h : reassembles NUM_CORES_H-wide beats of BLOCK_SIZE^2 blocks
// into BLOCK_SIZE-row strips and emits the matrix one COL-wide row at a time.
// Optional B2R_PINGPONG_EN: two strip banks with overlapped fill and drain.
// Revision 1.0
// ============================================================================
module b2r_converter_h #(
  parameter int WIDTH       = 16,
  parameter int FRAC_WIDTH  = 8,
  parameter int ROW         = 12,
  parameter int COL         = 12,
  parameter int BLOCK_SIZE  = 2,
  parameter int CHUNK_SIZE  = 4,
  parameter int NUM_CORES_H = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WIDTH*CHUNK_SIZE*NUM_CORES_H-1:0] in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [WIDTH*COL-1:0]                  out_data,
  output logic                                  row_last,
  output logic                                  buffer_done
);

  localparam int SPAN   = BLOCK_SIZE * NUM_CORES_H;
  localparam int BEATS  = COL / SPAN;
  localparam int STRIPS = ROW / BLOCK_SIZE;
`ifdef B2R_PINGPONG_EN
  localparam bit PINGPONG = 1'b1;
`else
  localparam bit PINGPONG = 1'b0;
`endif
  localparam int NUM_BANKS = PINGPONG ? 2 : 1;
  localparam int NROWS     = NUM_BANKS * BLOCK_SIZE;
  localparam int IW        = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam int CW        = (COL > 1) ? $clog2(COL) : 1;
  localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW        = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int SW        = $clog2(STRIPS + 1);

  generate
    if (CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE) begin : g_chk_chunk
      $error("b2r_converter_h: CHUNK_SIZE must equal BLOCK_SIZE*BLOCK_SIZE");
    end
    if ((ROW % BLOCK_SIZE) != 0) begin : g_chk_row
      $error("b2r_converter_h: ROW must be a multiple of BLOCK_SIZE");
    end
    if ((COL % SPAN) != 0) begin : g_chk_col
      $error("b2r_converter_h: COL must be a multiple of BLOCK_SIZE*NUM_CORES_H");
    end
    if (FRAC_WIDTH > WIDTH) begin : g_chk_frac
      $error("b2r_converter_h: FRAC_WIDTH exceeds WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] strip_buf [NROWS][COL];
  logic [BW-1:0]    beat_cnt;
  logic [RW-1:0]    row_cnt;
  logic [SW-1:0]    fill_strip;
  logic [SW-1:0]    drain_strip;
  logic             fill_sel;
  logic             drain_sel;
  logic [1:0]       bank_full;
  logic [IW-1:0]    rd_idx;

  logic accept, out_fire, fill_done, drain_done;
  logic last_fill, all_filled, last_drain, other_busy;

  assign in_ready   = en && (state == FILL) && !bank_full[fill_sel];
  assign out_valid  = en && bank_full[drain_sel];
  assign accept     = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign fill_done  = accept && (beat_cnt == BW'(BEATS - 1));
  assign drain_done = out_fire && (row_cnt == RW'(BLOCK_SIZE - 1));
  assign last_fill  = (fill_strip == SW'(STRIPS - 1));
  assign all_filled = (fill_strip == SW'(STRIPS));
  assign last_drain = (drain_strip == SW'(STRIPS - 1));
  // A finished fill may keep filling only if the opposite bank is free (or frees now).
  assign other_busy = PINGPONG ? (bank_full[~fill_sel] && !drain_done) : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (en) state <= next_state;
  end

  always_comb begin
    next_state  = state;
    buffer_done = 1'b0;
    case (state)
      IDLE:  next_state = FILL;
      FILL:  if (fill_done && (last_fill || other_busy)) next_state = DRAIN;
      DRAIN: begin
        if (drain_done) begin
          if (last_drain) next_state = DONE;
          else if (!all_filled) next_state = FILL;
        end
      end
      DONE: begin
        buffer_done = en;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
    row_last = (state == DRAIN) && last_drain && (row_cnt == RW'(BLOCK_SIZE - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt    <= '0;
      row_cnt     <= '0;
      fill_strip  <= '0;
      drain_strip <= '0;
      fill_sel    <= 1'b0;
      drain_sel   <= 1'b0;
      bank_full   <= '0;
    end else if (en) begin
      if (state == DONE) begin
        beat_cnt    <= '0;
        row_cnt     <= '0;
        fill_strip  <= '0;
        drain_strip <= '0;
        fill_sel    <= 1'b0;
        drain_sel   <= 1'b0;
        bank_full   <= '0;
      end else begin
        if (accept) begin
          beat_cnt <= fill_done ? '0 : beat_cnt + 1'b1;
          if (fill_done) begin
            bank_full[fill_sel] <= 1'b1;
            fill_strip          <= fill_strip + 1'b1;
            if (PINGPONG) fill_sel <= ~fill_sel;
          end
        end
        if (out_fire) begin
          row_cnt <= drain_done ? '0 : row_cnt + 1'b1;
          if (drain_done) begin
            bank_full[drain_sel] <= 1'b0;
            if (!last_drain) drain_strip <= drain_strip + 1'b1;
            if (PINGPONG) drain_sel <= ~drain_sel;
          end
        end
      end
    end
  end

  // Core k, block element (r,c): chunk slot k and element r*BS+c, both MSB-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NROWS; i++) begin
        for (int j = 0; j < COL; j++) strip_buf[i][j] <= '0;
      end
    end else if (accept) begin
      for (int r = 0; r < BLOCK_SIZE; r++) begin
        for (int k = 0; k < NUM_CORES_H; k++) begin
          for (int c = 0; c < BLOCK_SIZE; c++) begin
            strip_buf[IW'(int'(fill_sel) * BLOCK_SIZE + r)]
                     [CW'(int'(beat_cnt) * SPAN + k * BLOCK_SIZE + c)] <=
              in_data[((NUM_CORES_H - 1 - k) * CHUNK_SIZE +
                       (CHUNK_SIZE - 1 - (r * BLOCK_SIZE + c))) * WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  assign rd_idx = IW'(int'(drain_sel) * BLOCK_SIZE + int'(row_cnt));

  always_comb begin
    out_data = '0;
    for (int c = 0; c < COL; c++) begin
      out_data[(COL - 1 - c) * WIDTH +: WIDTH] = strip_buf[rd_idx][c];
    end
  end

endmodule
`default_nettype wire

// File: doc/b2r_converter_h.md
Name: b2r_converter_h

Overview:
- Block-to-row converter: the inverse of the row-to-block converter on the horizontal core array.
- Accepts beats of NUM_CORES_H horizontally adjacent BLOCK_SIZE x BLOCK_SIZE result blocks from the systolic cores.
- Assembles full BLOCK_SIZE-row strips of a ROW x COL matrix.
- Emits the matrix row-major, one COL-wide row per transfer, to the next stage.

Parameters:
- WIDTH, 16, bits per element
- FRAC_WIDTH, 8, fractional bits; pass-through only, no arithmetic
- ROW, 12, matrix rows; multiple of BLOCK_SIZE
- COL, 12, matrix columns; multiple of BLOCK_SIZE*NUM_CORES_H
- BLOCK_SIZE, 2, block edge length
- CHUNK_SIZE, 4, elements per core block; must equal BLOCK_SIZE*BLOCK_SIZE
- NUM_CORES_H, 3, blocks per input beat

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; low freezes all state and outputs
- in_valid  in  1  input beat valid
- in_ready  out  1  converter can accept a beat
- in_data  in  WIDTH*CHUNK_SIZE*NUM_CORES_H  NUM_CORES_H packed blocks
- out_valid  out  1  out_data holds a valid row
- out_ready  in  1  downstream accepts a row
- out_data  out  WIDTH*COL  one matrix row
- row_last  out  1  qualifies the last row of the matrix while out_valid
- buffer_done  out  1  one-cycle pulse after the last row of the matrix transfers

Behaviour:
- Derived constants:
  - BEATS = COL/(BLOCK_SIZE*NUM_CORES_H)
  - STRIPS = ROW/BLOCK_SIZE
- Packing, most-significant slot = index 0:
  - Core k block occupies chunk slot k.
  - Element (r,c) of that block sits at chunk index r*BLOCK_SIZE+c.
  - For beat b, the element's global column = b*BLOCK_SIZE*NUM_CORES_H + k*BLOCK_SIZE + c.
  - Output column 0 sits at out_data MSBs, i.e. out_data[(COL-1-col)*WIDTH +: WIDTH].
- Parameter violations (CHUNK_SIZE != BLOCK_SIZE^2, or a non-divisible ROW/COL) raise $error at elaboration.
- Reset values: in_ready=0, out_valid=0, out_data=0, row_last=0, buffer_done=0; strip buffer contents don't-care; FSM in IDLE.
- FSM states: IDLE, FILL, DRAIN, DONE.
  - IDLE: in_ready=0. Moves to FILL on the first cycle en=1.
  - FILL: in_ready=1. A transfer occurs when in_valid&&in_ready on a rising edge; the beat is written into strip-buffer columns for beat_cnt.
    - beat_cnt wraps at BEATS.
    - On acceptance of beat BEATS-1, go to DRAIN. out_valid=1 in the very next cycle, so latency is 1 cycle from the last beat.
  - DRAIN: out_valid=1 and in_ready=0, with out_data = strip row row_cnt.
    - A transfer occurs when out_valid&&out_ready; row_cnt then advances.
    - After row BLOCK_SIZE-1 transfers: if strip_cnt = STRIPS-1, go to DONE; otherwise increment strip_cnt and go to FILL.
    - out_data is stable while out_valid && !out_ready.
  - row_last=1 while DRAIN presents row BLOCK_SIZE-1 of strip STRIPS-1.
  - DONE: buffer_done=1 for exactly one cycle; all counters clear; return to IDLE.
- en=0: no state change, no transfer on either side.
  - in_ready and out_valid are forced to 0 combinationally while en=0.
  - out_data, row_last and the counters hold their values.
- in_valid while in_ready=0 is ignored; no data is captured.
- Asynchronous reset mid-FILL or mid-DRAIN discards the partial strip. The next matrix restarts at strip 0, beat 0.
- Sustained throughput: BEATS + BLOCK_SIZE cycles per strip.

Optional Feature:
- Macro: B2R_PINGPONG_EN.
- Defined:
  - Two strip buffers, A and B.
  - FILL and DRAIN run concurrently on opposite banks.
  - in_ready stays 1 during DRAIN while the other bank is free; it drops only when both banks are full.
  - Banks swap when a fill completes and the drain bank is empty.
  - Sustained throughput becomes max(BEATS, BLOCK_SIZE) cycles per strip.
  - buffer_done fires after the final row drains.
- Undefined: single buffer, behaviour as above; in_ready=0 throughout DRAIN.

Test Plan:
- Full matrix, defaults, out_ready=1:
  - Stimulus: element (r,c) = (r*12+c)<<8, packed into 12 beats.
  - Required: 12 rows in order. Row 0 = 0x0000,0x0100,...,0x0B00 MSB-first; row 11 ends 0x8F00. row_last only on row 11. buffer_done pulses once, one cycle after row 11 transfers.
- Latency:
  - Stimulus: beats 0 and 1 of strip 0 accepted on consecutive edges.
  - Required: out_valid high in the cycle right after beat 1 is accepted. in_ready=0 until both rows of the strip transfer (single-buffer build).
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1 during row 0.
  - Required: out_data held at row 0 while stalled. Row 1 is presented only after the second handshake. No rows lost or duplicated.
- Enable freeze:
  - Stimulus: en=0 for 5 cycles mid-FILL, with in_valid=1 held.
  - Required: beat_cnt unchanged, in_ready=0, no beat captured. Output after resume is identical to the uninterrupted run.
- Reset mid-DRAIN:
  - Stimulus: rst_n pulsed low while row 1 of strip 3 is pending.
  - Required: all outputs at reset values immediately. A fresh matrix afterwards yields row 0 first.
- With B2R_PINGPONG_EN:
  - Stimulus: in_valid and out_ready held at 1.
  - Required: in_ready stays 1 through each DRAIN. The full matrix completes in 6*2+2 cycles after the first beat, with identical row data.
